// File: rtl/hb_up_pkg.sv
// Shared definitions for the upstream heartbeat/data arbiter: word layout,
// heartbeat tag codes and the output-register state encoding.
package hb_up_pkg;

  localparam int NTIME = 48;
  localparam int NPAY  = 24;
  localparam int NCODE = 8;
  localparam int NCNT  = 16;

  localparam logic [NCODE-1:0] HB_LO_CODE = 8'hF0;
  localparam logic [NCODE-1:0] HB_HI_CODE = 8'hF1;

  typedef struct packed {
    logic [NCODE-1:0] code;
    logic [NPAY-1:0]  payload;
  } up_word_t;

  // Names the kind of word currently held in the output register.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    HB_LO = 2'd2,
    HB_HI = 2'd3
  } up_state_e;

endpackage

// File: rtl/up_word_reg.sv
// Valid/accept output register for the upstream word channel. It only
// changes when the arbiter has opened a slot, so the word is held under backpressure.
module up_word_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         slot_open,
  input  logic         load_v,
  input  logic [W-1:0] load_d,
  output logic         out_v,
  output logic [W-1:0] out_d
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_v <= 1'b0;
      out_d <= '0;
    end else if (slot_open) begin
      out_v <= load_v;
      if (load_v) begin
        out_d <= load_d;
      end
    end
  end

endmodule

// File: rtl/hb_up_arbiter.sv
// Interleaves core data words with two-word time heartbeats (HB_LO then HB_HI)
// on the single upstream channel; heartbeat times are snapshotted on request pulses.
module hb_up_arbiter
  import hb_up_pkg::*;
#(
  parameter int               Ntime      = hb_up_pkg::NTIME,
  parameter int               Npay       = hb_up_pkg::NPAY,
  parameter int               Ncode      = hb_up_pkg::NCODE,
  parameter logic [Ncode-1:0] HB_LO_CODE = hb_up_pkg::HB_LO_CODE,
  parameter logic [Ncode-1:0] HB_HI_CODE = hb_up_pkg::HB_HI_CODE,
  parameter int               Ncnt       = hb_up_pkg::NCNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_HB_up_pulse,
  input  logic [Ntime-1:0]      time_elapsed,
  input  logic                  hb_enable,
  input  logic                  in_v,
  input  logic [Ncode+Npay-1:0] in_d,
  output logic                  in_a,
  output logic                  out_v,
  output logic [Ncode+Npay-1:0] out_d,
  input  logic                  out_a,
  output logic [Ncnt-1:0]       hb_coalesced
);

  localparam int W = Ncode + Npay;

  if (Ntime != 2 * Npay) begin : g_width_check
    $error("hb_up_arbiter: Ntime must equal 2*Npay");
  end

  // Handshake: a word moves on any edge where out_v & out_a; in_d is taken
  // on an edge where in_v & in_a, and in_a is only raised when it is loaded.

  up_state_e        state_q, state_d;
  logic             slot_open;
  logic             pulse_take;
  logic             sel_lo, sel_hi, sel_data;
  logic [Ntime-1:0] snap, hbuf;
  logic             hb_pending, hb_hi_due, last_was_hb;
  logic             load_v;
  logic [W-1:0]     load_d;

  assign slot_open  = reset & (~out_v | out_a);
  assign pulse_take = send_HB_up_pulse & hb_enable;

  assign sel_hi   = slot_open && (state_d == HB_HI);
  assign sel_lo   = slot_open && (state_d == HB_LO);
  assign sel_data = slot_open && (state_d == DATA);

  // State register: the kind of word sitting in the output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the slot fill decision. A finished pair gives one waiting
  // data word priority before the next heartbeat pair.
  always_comb begin
    state_d = state_q;
    if (slot_open) begin
      if (hb_hi_due) begin
        state_d = HB_HI;
      end else if (hb_pending && (!last_was_hb || !in_v)) begin
        state_d = HB_LO;
      end else if (in_v) begin
        state_d = DATA;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Outputs: the word loaded into the output register and the data accept.
  always_comb begin
    load_v = 1'b0;
    load_d = '0;
    in_a   = 1'b0;
    if (slot_open) begin
      case (state_d)
        HB_HI: begin
          load_v = 1'b1;
          load_d = {HB_HI_CODE, hbuf[Ntime-1:Npay]};
        end
        HB_LO: begin
          load_v = 1'b1;
          load_d = {HB_LO_CODE, snap[Npay-1:0]};
        end
        DATA: begin
          load_v = 1'b1;
          load_d = in_d;
          in_a   = 1'b1;
        end
        default: begin
          load_v = 1'b0;
        end
      endcase
    end
  end

  // Heartbeat bookkeeping. HB_HI is taken from hbuf so a pulse arriving
  // between the halves only refreshes snap and re-pends a new pair.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snap         <= '0;
      hbuf         <= '0;
      hb_pending   <= 1'b0;
      hb_hi_due    <= 1'b0;
      last_was_hb  <= 1'b0;
      hb_coalesced <= '0;
    end else begin
      if (pulse_take) begin
        snap <= time_elapsed;
      end
      if (pulse_take) begin
        hb_pending <= 1'b1;
      end else if (sel_lo) begin
        hb_pending <= 1'b0;
      end
      if (pulse_take && hb_pending && !sel_lo && (hb_coalesced != '1)) begin
        hb_coalesced <= hb_coalesced + 1'b1;
      end
      if (sel_lo) begin
        hbuf      <= snap;
        hb_hi_due <= 1'b1;
      end
      if (sel_hi) begin
        hb_hi_due   <= 1'b0;
        last_was_hb <= 1'b1;
      end
      if (sel_data) begin
        last_was_hb <= 1'b0;
      end
    end
  end

  up_word_reg #(
    .W(W)
  ) u_word_reg (
    .clk      (clk),
    .reset    (reset),
    .slot_open(slot_open),
    .load_v   (load_v),
    .load_d   (load_d),
    .out_v    (out_v),
    .out_d    (out_d)
  );

endmodule
